// File: rtl/coeff_pwl_eval.sv
// Piecewise-linear segment evaluator: y = slope*x + icpt, with the segment
// chosen by the coefficient read pointer. Three registered stages, valid/ready on both sides.

module coeff_pwl_sat #(
    parameter int DATA_W = 16
) (
    input  logic signed [2*DATA_W:0]  sum,
    output logic        [DATA_W-1:0]  y,
    output logic                      sat
);
    localparam logic signed [2*DATA_W:0] SAT_MAX = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W:0] SAT_MIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    always_comb begin
        y   = sum[DATA_W-1:0];
        sat = 1'b0;
        if (sum > SAT_MAX) begin
            y   = SAT_MAX[DATA_W-1:0];
            sat = 1'b1;
        end else if (sum < SAT_MIN) begin
            y   = SAT_MIN[DATA_W-1:0];
            sat = 1'b1;
        end
    end
endmodule

module coeff_pwl_eval #(
    parameter int ADDR_LINES = 4,
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8
) (
    input  logic                  clkn_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_LINES-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]     wr_slope_i,
    input  logic [DATA_W-1:0]     wr_icpt_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_x_i,
    input  logic [ADDR_LINES-1:0] rd_ptr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     out_y_o,
    output logic                  sat_o
);
    localparam int DEPTH  = 1 << ADDR_LINES;
    localparam int STAGES = 3;

    typedef struct packed {
        logic [DATA_W-1:0] slope;
        logic [DATA_W-1:0] icpt;
    } coeff_t;

    typedef struct packed {
        logic [DATA_W-1:0] x;
        coeff_t            c;
    } s1_t;

    typedef struct packed {
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W-1:0]   icpt;
    } s2_t;

    coeff_t              mem [DEPTH];
    s1_t                 s1_q;
    s2_t                 s2_q;
    logic [STAGES:1]     vld_pipe;
    logic                stall;
    logic                accept;
    logic signed [2*DATA_W-1:0] prod_d;
    logic signed [2*DATA_W-1:0] sh_d;
    logic signed [2*DATA_W:0]   sum_d;
    logic [DATA_W-1:0]   sat_y;
    logic                sat_flag;

    assign out_valid_o = vld_pipe[STAGES];
    assign stall       = out_valid_o && !out_ready_i;
    assign in_ready_o  = !stall;
    assign accept      = in_valid_i && in_ready_o;

    // Read-before-write: a sample accepted on a write edge sees the old entry.
    always_ff @(posedge clkn_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en_i) begin
            mem[wr_addr_i] <= {wr_slope_i, wr_icpt_i};
        end
    end

    assign prod_d = $signed(s1_q.x) * $signed(s1_q.c.slope);
    assign sh_d   = $signed(s2_q.prod) >>> FRAC_W;
    assign sum_d  = $signed({sh_d[2*DATA_W-1], sh_d})
                  + $signed({{(DATA_W+1){s2_q.icpt[DATA_W-1]}}, s2_q.icpt});

    coeff_pwl_sat #(.DATA_W(DATA_W)) u_sat (
        .sum (sum_d),
        .y   (sat_y),
        .sat (sat_flag)
    );

    // The whole pipe freezes on stall; bubbles move forward as cleared valids.
    always_ff @(posedge clkn_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            out_y_o  <= '0;
            sat_o    <= 1'b0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            if (accept)
                s1_q <= {in_x_i, mem[rd_ptr_i]};
            if (vld_pipe[1])
                s2_q <= {prod_d, s1_q.c.icpt};
            if (vld_pipe[2]) begin
                out_y_o <= sat_y;
                sat_o   <= sat_flag;
            end
        end
    end
endmodule

// File: tb/tb_coeff_pwl_eval.sv
// Directed bench for coeff_pwl_eval: hand-computed vectors checked with immediate assertions.

module tb_coeff_pwl_eval;
    logic        clkn_i = 1'b0;
    logic        rst_i;
    logic        wr_en_i;
    logic [3:0]  wr_addr_i;
    logic [15:0] wr_slope_i;
    logic [15:0] wr_icpt_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_x_i;
    logic [3:0]  rd_ptr_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_y_o;
    logic        sat_o;

    int n_assert = 0;
    int n_fail   = 0;

    coeff_pwl_eval #(.ADDR_LINES(4), .DATA_W(16), .FRAC_W(8)) dut (
        .clkn_i      (clkn_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_slope_i  (wr_slope_i),
        .wr_icpt_i   (wr_icpt_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_x_i      (in_x_i),
        .rd_ptr_i    (rd_ptr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_y_o     (out_y_o),
        .sat_o       (sat_o)
    );

    always #5 clkn_i = ~clkn_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clkn_i);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] s, input logic [15:0] c);
        wr_en_i = 1'b1; wr_addr_i = a; wr_slope_i = s; wr_icpt_i = c;
        step();
        wr_en_i = 1'b0;
    endtask

    // Present one sample and follow it through the three stages.
    task automatic send_one(input string tag, input logic [15:0] x, input logic [3:0] p,
                            input logic [15:0] ey, input logic es);
        in_valid_i = 1'b1; in_x_i = x; rd_ptr_i = p;
        #1;
        chk({tag, ".in_ready"}, in_ready_o, 1);
        step();
        in_valid_i = 1'b0;
        chk({tag, ".v1"}, out_valid_o, 0);
        step();
        chk({tag, ".v2"}, out_valid_o, 0);
        step();
        chk({tag, ".v3"}, out_valid_o, 1);
        chk({tag, ".y"}, out_y_o, ey);
        chk({tag, ".sat"}, sat_o, es);
        step();
        chk({tag, ".drain"}, out_valid_o, 0);
        chk({tag, ".hold"}, out_y_o, ey);
    endtask

    initial begin
        logic [15:0] exp_y [6];
        int sent, recv, c;

        rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_slope_i = '0; wr_icpt_i = '0;
        in_valid_i = 1'b0; in_x_i = '0; rd_ptr_i = '0; out_ready_i = 1'b1;
        step();
        step();
        chk("rst.valid", out_valid_o, 0);
        chk("rst.y", out_y_o, 0);
        chk("rst.sat", sat_o, 0);
        chk("rst.in_ready", in_ready_o, 1);
        rst_i = 1'b0;

        // Basic evaluation: 1.5*2.0 + 1.0 = 4.0
        wr(4'd3, 16'h0200, 16'h0100);
        send_one("t1", 16'h0180, 4'd3, 16'h0400, 1'b0);

        // Negative slope and floor truncation
        wr(4'd5, 16'hFF00, 16'h0000);
        send_one("t2a", 16'h0080, 4'd5, 16'hFF80, 1'b0);
        wr(4'd5, 16'h0001, 16'h0000);
        send_one("t2b", 16'hFFFF, 4'd5, 16'hFFFF, 1'b0);

        // Saturation at both rails
        wr(4'd6, 16'h7FFF, 16'h7FFF);
        send_one("t3hi", 16'h7FFF, 4'd6, 16'h7FFF, 1'b1);
        wr(4'd6, 16'h7FFF, 16'h8000);
        send_one("t3lo", 16'h8000, 4'd6, 16'h8000, 1'b1);

        // Back-to-back stream with a 4-cycle downstream stall
        wr(4'd7, 16'h0100, 16'h0010);
        for (int k = 0; k < 6; k++)
            exp_y[k] = 16'((k + 1) * 256 + 16);
        sent = 0; recv = 0; c = 0;
        while (recv < 6 && c < 40) begin
            out_ready_i = !(c >= 4 && c < 8);
            in_valid_i  = (sent < 6);
            in_x_i      = 16'((sent + 1) * 256);
            rd_ptr_i    = 4'd7;
            #1;
            if (!out_ready_i) begin
                chk("t4.stall_valid", out_valid_o, 1);
                chk("t4.stall_ready", in_ready_o, 0);
            end
            if (in_valid_i && in_ready_o)
                sent++;
            if (out_valid_o && out_ready_i) begin
                chk($sformatf("t4.y%0d", recv), out_y_o, exp_y[recv]);
                recv++;
            end
            step();
            c++;
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        chk("t4.recv", recv, 6);
        chk("t4.sent", sent, 6);
        chk("t4.nodup", out_valid_o, 0);

        // Write and accept on the same edge to the same address
        wr(4'd2, 16'h0100, 16'h0000);
        wr_en_i = 1'b1; wr_addr_i = 4'd2; wr_slope_i = 16'h0300; wr_icpt_i = 16'h0000;
        in_valid_i = 1'b1; in_x_i = 16'h0100; rd_ptr_i = 4'd2;
        step();
        wr_en_i = 1'b0;
        step();
        in_valid_i = 1'b0;
        step();
        chk("t5.v_old", out_valid_o, 1);
        chk("t5.y_old", out_y_o, 16'h0100);
        step();
        chk("t5.v_new", out_valid_o, 1);
        chk("t5.y_new", out_y_o, 16'h0300);
        step();
        chk("t5.drain", out_valid_o, 0);

        // Reset with samples in flight
        in_valid_i = 1'b1; in_x_i = 16'h0180; rd_ptr_i = 4'd3;
        step();
        step();
        step();
        in_valid_i = 1'b0;
        chk("t6.pre_valid", out_valid_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("t6.valid", out_valid_o, 0);
        chk("t6.y", out_y_o, 0);
        chk("t6.sat", sat_o, 0);
        step();
        chk("t6.stale1", out_valid_o, 0);
        step();
        chk("t6.stale2", out_valid_o, 0);
        send_one("t6.a3", 16'h0180, 4'd3, 16'h0000, 1'b0);
        send_one("t6.a6", 16'h7FFF, 4'd6, 16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
